frame_serializer_mc: RTL

FRAME_SERIALIZER_MC -- requirements
Module: frame_serializer_mc

---
 rtl/frame_ser_pkg.sv | 19 +
 rtl/frame_ser_parity.sv | 11 +
 rtl/frame_serializer_mc.sv | 107 ++++++++++
 3 files changed

// File: rtl/frame_ser_pkg.sv
// Shared types and sizing helpers for the frame serializer.
package frame_ser_pkg;

    // Two-state FSM, kept as plain logic constants for older tooling.
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SHIFT = 1'b1;

    // Bits per frame: all channel samples plus the optional parity bit.
    function automatic int frame_len(input int data_w, input int n_ch, input int parity_en);
        return data_w * n_ch + parity_en;
    endfunction

    // Width of the bit counter; never below one bit.
    function automatic int cnt_w(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/frame_ser_parity.sv
// Even parity over the packed sample set.
module frame_ser_parity #(
    parameter int W = 44
) (
    input  logic [W-1:0] data,
    output logic         parity
);

    assign parity = ^data;

endmodule

// File: rtl/frame_serializer_mc.sv
// Multi-channel frame serializer: packs N_CH samples (plus even parity)
// into one serial frame with a sync pulse on the first bit.
module frame_serializer_mc
    import frame_ser_pkg::*;
#(
    parameter int DATA_W    = 22,
    parameter int N_CH      = 2,
    parameter int PARITY_EN = 1
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic [N_CH*DATA_W-1:0] data_i,
    input  logic                   valid_i,
    input  logic                   msb_first_i,
    output logic                   ready_o,
    output logic                   data_o,
    output logic                   frame_sync_o,
    output logic                   overrun_o
);

    localparam int NW        = N_CH * DATA_W;
    localparam int FRAME_LEN = frame_len(DATA_W, N_CH, PARITY_EN);
    localparam int CW        = cnt_w(FRAME_LEN);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [FRAME_LEN-1:0]   frame_q;    // bits still to send, next one in bit 0
    logic [FRAME_LEN-1:0]   frame_lin;  // incoming frame in transmission order
    logic [NW-1:0]          data_ord;
    logic                   valid_q;
    logic                   accept;

    assign ready_o = (state_q == ST_IDLE) || (cnt_q == LAST);
    assign accept  = valid_i && ready_o;

    // Reorder the incoming samples into transmission order so the frame
    // register only ever shifts right; bit order is resolved at accept.
    always_comb begin
        data_ord = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            for (int b = 0; b < DATA_W; b++) begin
                data_ord[ch*DATA_W + b] = msb_first_i ? data_i[ch*DATA_W + DATA_W - 1 - b]
                                                      : data_i[ch*DATA_W + b];
            end
        end
    end

    // Parity bit rides on top of the data so it is sent last.
    generate
        if (PARITY_EN != 0) begin : g_par
            logic par;
            frame_ser_parity #(.W(NW)) u_parity (
                .data   (data_i),
                .parity (par)
            );
            assign frame_lin = {par, data_ord};
        end else begin : g_nopar
            assign frame_lin = data_ord;
        end
    endgenerate

    // FSM, bit counter and output shift register. cnt_q tracks the index of
    // the bit currently on data_o; an accept on the last bit chains frames.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            frame_q      <= '0;
            data_o       <= 1'b0;
            frame_sync_o <= 1'b0;
        end else begin
            frame_sync_o <= 1'b0;
            if (accept) begin
                state_q      <= ST_SHIFT;
                cnt_q        <= '0;
                frame_q      <= frame_lin >> 1;
                data_o       <= frame_lin[0];
                frame_sync_o <= 1'b1;
            end else if (state_q == ST_SHIFT) begin
                if (cnt_q == LAST) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    data_o  <= 1'b0;
                end else begin
                    cnt_q   <= cnt_q + CW'(1);
                    data_o  <= frame_q[0];
                    frame_q <= frame_q >> 1;
                end
            end
        end
    end

    // Overrun flags a newly asserted valid_i that cannot be taken. A valid_i
    // held high is one sample set waiting for the next accept slot, so it is
    // not counted again every busy cycle.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid_q   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            valid_q   <= valid_i;
            overrun_o <= valid_i && !valid_q && !ready_o;
        end
    end

endmodule
